// File: rtl/aes_stream_packer.sv
`timescale 1ns/1ps
// aes_stream_packer
// Packs a 32-bit plaintext word stream into 128-bit blocks, hands each block
// plus the job key to an external AES core, and unpacks the returned
// ciphertext into a 32-bit word stream. A job covers n_blocks blocks and is
// launched by a one-cycle start pulse.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   clear             : synchronous soft clear (beats start and handshakes)
//   start, n_blocks,  : job launch; n_blocks and key are latched at start
//   key
//   pt_valid/ready/data   : plaintext word stream in (word 0 = MSW)
//   core_start, core_block, core_key : request to the AES core
//   core_done, core_result           : completion pulse and ciphertext
//   ct_valid/ready/data   : ciphertext word stream out (word 0 = MSW)
//   busy, done, blk_cnt   : status; done is a one-cycle pulse, blk_cnt
//                           counts blocks completed in the current job
// All outputs are registered.
module aes_stream_packer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] n_blocks,
  input  logic [127:0]     key,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [31:0]      pt_data,
  output logic             core_start,
  output logic [127:0]     core_block,
  output logic [127:0]     core_key,
  input  logic             core_done,
  input  logic [127:0]     core_result,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [31:0]      ct_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = BLK_W / WORD_W;
  localparam int unsigned IDX_W  = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CIPHER  = 3'd2,
    S_EMIT    = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     nblk_q, nblk_d;
  logic [BLK_W-1:0]     ct_buf_q, ct_buf_d;
  logic [BLK_W-1:0]     core_block_q, core_block_d;
  logic [BLK_W-1:0]     core_key_q, core_key_d;
  logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
  logic                 pt_ready_q, pt_ready_d;
  logic                 core_start_q, core_start_d;
  logic                 ct_valid_q, ct_valid_d;
  logic [WORD_W-1:0]    ct_data_q, ct_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 pt_fire;
  logic                 ct_fire;
  logic [CNT_W-1:0]     blk_inc;

  // Word i of a block lives at bits [127-32i -: 32] (word 0 is the MSW).
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                 input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    unique case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [BLK_W-1:0] word_ins(input logic [BLK_W-1:0]  blk,
                                                input logic [IDX_W-1:0]  idx,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] b;
    b = blk;
    unique case (idx)
      2'd0:    b[127:96] = w;
      2'd1:    b[95:64]  = w;
      2'd2:    b[63:32]  = w;
      default: b[31:0]   = w;
    endcase
    return b;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      nblk_q       <= '0;
      ct_buf_q     <= '0;
      core_block_q <= '0;
      core_key_q   <= '0;
      blk_cnt_q    <= '0;
      pt_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      ct_valid_q   <= 1'b0;
      ct_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      nblk_q       <= nblk_d;
      ct_buf_q     <= ct_buf_d;
      core_block_q <= core_block_d;
      core_key_q   <= core_key_d;
      blk_cnt_q    <= blk_cnt_d;
      pt_ready_q   <= pt_ready_d;
      core_start_q <= core_start_d;
      ct_valid_q   <= ct_valid_d;
      ct_data_q    <= ct_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nblk_d       = nblk_q;
    ct_buf_d     = ct_buf_q;
    core_block_d = core_block_q;
    core_key_d   = core_key_q;
    blk_cnt_d    = blk_cnt_q;
    ct_data_d    = ct_data_q;
    pt_ready_d   = 1'b0;
    core_start_d = 1'b0;
    ct_valid_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    pt_fire = pt_valid && pt_ready_q;
    ct_fire = ct_valid_q && ct_ready;
    blk_inc = blk_cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nblk_d     = n_blocks;
          core_key_d = key;
          blk_cnt_d  = '0;
          idx_d      = '0;
          state_d    = (n_blocks != '0) ? S_COLLECT : S_FINISH;
        end
      end
      S_COLLECT: begin
        if (pt_fire) begin
          core_block_d = word_ins(core_block_q, idx_q, pt_data);
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_CIPHER;
          end
        end
      end
      S_CIPHER: begin
        if (core_done) begin
          ct_buf_d = core_result;
          idx_d    = '0;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (ct_fire) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            blk_cnt_d = blk_inc;
            state_d   = (blk_inc == nblk_q) ? S_FINISH : S_COLLECT;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Soft clear overrides everything decided above.
    if (clear) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      nblk_d       = '0;
      ct_buf_d     = '0;
      core_block_d = '0;
      core_key_d   = '0;
      blk_cnt_d    = '0;
    end

    // Outputs are registered copies of what the next state implies.
    pt_ready_d   = (state_d == S_COLLECT);
    ct_valid_d   = (state_d == S_EMIT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FINISH);
    core_start_d = (state_d == S_CIPHER) && (state_q != S_CIPHER);

    // ct_data follows the word index in EMIT and holds otherwise, so it
    // stays put across a stalled handshake.
    if (state_d == S_EMIT) begin
      ct_data_d = word_sel(ct_buf_d, idx_d);
    end else if (clear) begin
      ct_data_d = '0;
    end
  end

  assign pt_ready   = pt_ready_q;
  assign core_start = core_start_q;
  assign core_block = core_block_q;
  assign core_key   = core_key_q;
  assign ct_valid   = ct_valid_q;
  assign ct_data    = ct_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
`timescale 1ns/1ps
// Self-checking bench for aes_stream_packer: job table plus hand sequences
// for disturbances, soft clear and asynchronous reset.
module tb_aes_stream_packer;

  localparam int unsigned CNT_W = 16;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk, reset, clear, start;
  logic [CNT_W-1:0] n_blocks;
  logic [127:0]     key;
  logic             pt_valid, pt_ready;
  logic [31:0]      pt_data;
  logic             core_start;
  logic [127:0]     core_block, core_key;
  logic             core_done;
  logic [127:0]     core_result;
  logic             ct_valid, ct_ready;
  logic [31:0]      ct_data;
  logic             busy, done;
  logic [CNT_W-1:0] blk_cnt;

  aes_stream_packer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .n_blocks(n_blocks), .key(key),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .core_start(core_start), .core_block(core_block), .core_key(core_key),
    .core_done(core_done), .core_result(core_result),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Stand-in cipher: the real FIPS-197 answer for the known vector,
  // otherwise an invertible mix of block and key.
  function automatic logic [127:0] core_fn(input logic [127:0] b, input logic [127:0] k);
    if (b == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {b[95:0], b[127:96]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Shared environment state.
  logic [31:0]  pt_q[$];
  logic [31:0]  got_ct[$];
  int unsigned  gap_pct = 0;
  int unsigned  stall_pct = 0;
  int n_cs = 0, n_done = 0, n_ctv = 0, n_ptr = 0, n_pt_acc = 0;
  int stab_err = 0, stall_err = 0, lat_err = 0;
  int t = 0, done_t = 0, last_ct_t = 0, last_pt_t = 0, start_t = 0, core_done_t = 0;
  bit spur_req = 0;
  logic [127:0] cs_block = '0;

  // Monitor plus AES core model; everything is sampled mid-cycle.
  initial begin : mon
    logic [127:0] cap_blk, cap_key;
    logic [31:0]  stall_data;
    bit pending, stalled, ctv_prev;
    int cnt;
    pending = 0; stalled = 0; ctv_prev = 0; cnt = 0;
    cap_blk = '0; cap_key = '0; stall_data = '0;
    core_done = 1'b0; core_result = '0;
    forever begin
      @(negedge clk);
      t++;
      if (core_start) begin
        n_cs++; cs_block = core_block;
        if (t - last_pt_t != 1) lat_err++;
      end
      if (done) begin n_done++; done_t = t; end
      if (ct_valid) n_ctv++;
      if (pt_ready) n_ptr++;
      if (pt_valid && pt_ready) begin n_pt_acc++; last_pt_t = t; end
      if (start && !busy) start_t = t;
      if (ct_valid && !ctv_prev && (t - core_done_t != 1)) lat_err++;
      if (stalled && ct_valid && ct_data !== stall_data) stall_err++;
      stalled    = ct_valid && !ct_ready;
      stall_data = ct_data;
      ctv_prev   = ct_valid;
      if (ct_valid && ct_ready) begin got_ct.push_back(ct_data); last_ct_t = t; end
      // core: done 10 cycles after core_start, inputs must stay stable
      core_done = 1'b0;
      if (reset || !busy) pending = 0;
      if (pending) begin
        if (core_block !== cap_blk || core_key !== cap_key) stab_err++;
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1; core_result = core_fn(cap_blk, cap_key);
          pending = 0; core_done_t = t;
        end
      end else if (spur_req) begin
        core_done = 1'b1; core_result = {$urandom, $urandom, $urandom, $urandom};
        spur_req = 0;
      end
      if (core_start) begin pending = 1; cnt = 10; cap_blk = core_block; cap_key = core_key; end
    end
  end

  // Plaintext source with random gaps.
  initial begin : src
    bit fire;
    pt_valid = 1'b0; pt_data = '0;
    forever begin
      @(negedge clk);
      fire = pt_valid && pt_ready;
      @(posedge clk); #1;
      if (fire && pt_q.size() > 0) void'(pt_q.pop_front());
      if (pt_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        pt_valid = 1'b1; pt_data = pt_q[0];
      end else begin
        pt_valid = 1'b0;
      end
    end
  end

  // Ciphertext sink with random back-pressure.
  initial begin : snk
    ct_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ct_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  // One job from start to done, scored against the block-level model.
  task automatic run_job(input logic [CNT_W-1:0] nb, input logic [127:0] k, input bit fips,
                         input bit disturb, input int unsigned exp_cnt, input int unsigned exp_cs,
                         input int unsigned exp_words, input string tag);
    logic [127:0] blk, e;
    logic [31:0]  exp_q[$];
    int cyc, exp_done_t;
    pt_q.delete(); got_ct.delete();
    n_cs = 0; n_done = 0; n_pt_acc = 0; n_ptr = 0;
    stall_err = 0; stab_err = 0; lat_err = 0;
    for (int b = 0; b < int'(nb); b++) begin
      blk = fips ? FIPS_PT : {$urandom, $urandom, $urandom, $urandom};
      e = core_fn(blk, k);
      for (int w = 0; w < 4; w++) begin
        pt_q.push_back(blk[127-32*w -: 32]);
        exp_q.push_back(e[127-32*w -: 32]);
      end
    end
    n_blocks = nb; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      if (disturb && cyc == 1) begin spur_req = 1; start = 1'b1; n_blocks = 16'd7; end
      else if (disturb && cyc == 2) begin start = 1'b0; n_blocks = nb; end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, 128'(n_done != 0), 128'(1));
    exp_done_t = (exp_words != 0) ? last_ct_t + 1 : start_t + 1;
    check({tag, "_done_latency"}, 128'(done_t), 128'(exp_done_t));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 128'(n_done), 128'(1));
    check({tag, "_core_starts"}, 128'(n_cs), 128'(exp_cs));
    check({tag, "_pt_words"}, 128'(n_pt_acc), 128'(exp_words));
    check({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(exp_cnt));
    check({tag, "_busy_idle"}, 128'(busy), 128'(0));
    check({tag, "_ct_count"}, 128'(got_ct.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_ct.size(); i++)
      check($sformatf("%s_ct%0d", tag, i), 128'(got_ct[i]), 128'(exp_q[i]));
    check({tag, "_stall_stable"}, 128'(stall_err), 128'(0));
    check({tag, "_core_in_stable"}, 128'(stab_err), 128'(0));
    check({tag, "_latency"}, 128'(lat_err), 128'(0));
    if (exp_words == 0) check({tag, "_no_pt_ready"}, 128'(n_ptr), 128'(0));
  endtask

  typedef struct packed {
    int unsigned nb;
    int unsigned gap;
    int unsigned stall;
    int unsigned exp_cnt;
    int unsigned exp_cs;
    int unsigned exp_words;
  } vec_t;

  initial begin : main
    vec_t vecs[5];
    logic [127:0] fips_ct;
    int cyc;
    vecs[0] = '{nb: 1, gap: 0,  stall: 0,  exp_cnt: 1, exp_cs: 1, exp_words: 4};
    vecs[1] = '{nb: 0, gap: 0,  stall: 0,  exp_cnt: 0, exp_cs: 0, exp_words: 0};
    vecs[2] = '{nb: 3, gap: 40, stall: 40, exp_cnt: 3, exp_cs: 3, exp_words: 12};
    vecs[3] = '{nb: 2, gap: 70, stall: 20, exp_cnt: 2, exp_cs: 2, exp_words: 8};
    vecs[4] = '{nb: 5, gap: 10, stall: 60, exp_cnt: 5, exp_cs: 5, exp_words: 20};

    reset = 1'b1; clear = 1'b0; start = 1'b0; n_blocks = '0; key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 128'({pt_ready, ct_valid, core_start, busy, done}), 128'(0));
    check("rst_ct_data", 128'(ct_data), 128'(0));
    check("rst_core_block", core_block, 128'(0));
    check("rst_core_key", core_key, 128'(0));
    check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Known-answer single block.
    gap_pct = 0; stall_pct = 0;
    run_job(16'd1, FIPS_KEY, 1'b1, 1'b0, 1, 1, 4, "fips");
    fips_ct = FIPS_CT;
    check("fips_core_block", cs_block, FIPS_PT);
    check("fips_core_key", core_key, FIPS_KEY);
    for (int i = 0; i < 4 && i < got_ct.size(); i++)
      check($sformatf("fips_kat%0d", i), 128'(got_ct[i]), 128'(fips_ct[127-32*i -: 32]));

    // Job table with random gaps and stalls.
    for (int v = 0; v < 5; v++) begin
      gap_pct = vecs[v].gap; stall_pct = vecs[v].stall;
      run_job(CNT_W'(vecs[v].nb), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0,
              vecs[v].exp_cnt, vecs[v].exp_cs, vecs[v].exp_words, $sformatf("vec%0d", v));
    end

    // Spurious core_done in COLLECT and start while busy.
    gap_pct = 20; stall_pct = 20;
    run_job(16'd2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 2, 2, 8, "disturb");

    // Clear together with start, mid-EMIT of the second block.
    gap_pct = 0; stall_pct = 0;
    pt_q.delete(); got_ct.delete(); n_done = 0;
    for (int i = 0; i < 8; i++) pt_q.push_back($urandom);
    n_blocks = 16'd2; key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (got_ct.size() < 6 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check("clr_reach_emit", 128'(got_ct.size()), 128'(6));
    check("clr_blk_cnt_before", 128'(blk_cnt), 128'(1));
    clear = 1'b1; start = 1'b1; n_blocks = 16'd3;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    check("clr_ctrl", 128'({busy, ct_valid, pt_ready, core_start, done}), 128'(0));
    check("clr_blk_cnt", 128'(blk_cnt), 128'(0));
    check("clr_data", {96'(ct_data), 32'(core_block[31:0])}, 128'(0));
    check("clr_core_block", core_block, 128'(0));
    repeat (4) @(posedge clk);
    #1;
    check("clr_no_done", 128'(n_done), 128'(0));
    check("clr_stays_idle", 128'(busy), 128'(0));
    pt_q.delete();

    // Asynchronous reset while the core is working.
    pt_q.delete(); got_ct.delete(); n_cs = 0;
    for (int i = 0; i < 4; i++) pt_q.push_back($urandom);
    n_blocks = 16'd1; key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (n_cs == 0 && cyc < 500) begin @(posedge clk); #1; cyc++; end
    check("rst_reach_cipher", 128'(n_cs), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_ctrl", 128'({busy, pt_ready, ct_valid, core_start, done}), 128'(0));
    check("arst_core_block", core_block, 128'(0));
    check("arst_core_key", core_key, 128'(0));
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    n_cs = 0; n_ctv = 0; n_done = 0;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_core_start", 128'(n_cs), 128'(0));
    check("arst_no_ct_valid", 128'(n_ctv), 128'(0));
    check("arst_no_done", 128'(n_done), 128'(0));
    gap_pct = 30; stall_pct = 30;
    run_job(16'd1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1, 1, 4, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
